// File: rtl/spi_master.sv
// spi_master: CPOL/CPHA-configurable SPI master for NBYTES-byte frames; define SPI_MASTER_LSB_FIRST_EN to shift LSB first.
module spi_master #(
  parameter int NBYTES = 1,
  parameter int CLKDIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                start,
  input  logic [8*NBYTES-1:0] din,
  output logic [8*NBYTES-1:0] dout,
  output logic                busy,
  output logic                done,
  output logic                select,
  output logic                mclk,
  output logic                mosi,
  input  logic                miso
);
  localparam int W  = 8*NBYTES;
  localparam int CW = $clog2(CLKDIV+1);
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
  state_t state;
  logic [W-1:0] sr, sr_in;
  logic [CW-1:0] cnt;
  logic [5:0] edges;
  logic cpol_l, cpha_l, tick, sample, drive, out_bit, first_bit;
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign sr_in     = {miso, sr[W-1:1]};
  assign out_bit   = sr[0];
  assign first_bit = din[0];
`else
  assign sr_in     = {sr[W-2:0], miso};
  assign out_bit   = sr[W-1];
  assign first_bit = din[W-1];
`endif
  assign busy   = state != IDLE;
  assign tick   = cnt == CW'(CLKDIV-1);
  // an even count of remaining edges means the next toggle is a leading edge
  assign sample = ~edges[0] ^ cpha_l;
  assign drive  = ~sample && edges != 6'd1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      select <= 1'b0;
      mclk   <= cpol;
      mosi   <= 1'b0;
      done   <= 1'b0;
      dout   <= '0;
      sr     <= '0;
      cnt    <= '0;
      edges  <= '0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mclk <= cpol;
          if (start && !done) begin
            cpol_l <= cpol;
            cpha_l <= cpha;
            sr     <= din;
            mosi   <= first_bit;
            select <= 1'b1;
            cnt    <= '0;
            edges  <= 6'(16*NBYTES);
            state  <= LEAD;
          end
        end
        LEAD: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) state <= SHIFT;
        end
        SHIFT: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            mclk  <= ~mclk;
            edges <= edges - 1'b1;
            if (sample) sr <= sr_in;
            if (drive) mosi <= out_bit;
            if (edges == 6'd1) state <= TRAIL;
          end
        end
        TRAIL: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(CLKDIV)) begin
            select <= 1'b0;
            mclk   <= cpol_l;
            dout   <= sr;
            done   <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed table-driven bench for spi_master with NBYTES=1 and NBYTES=2 instances, CLKDIV=4.
module tb_spi_master;
  logic clk = 1'b0;
  logic reset, cpol, cpha, start, loop, miso_s, miso;
  logic [7:0] din, dout;
  logic busy, done, select, mclk, mosi;
  logic start2, miso2;
  logic [15:0] din2, dout2;
  logic busy2, done2, select2, mclk2, mosi2;
  int tests = 0, fails = 0;
  int r_cyc, r_edges;
  logic r_mosi_low, r_first, r_busy_done;
  logic [7:0] r_wire;
  typedef struct {
    logic p, h, lb;
    logic [7:0] d, pat, exp;
  } vec_t;
  vec_t vt [8];

  assign miso  = loop ? mosi : miso_s;
  assign miso2 = mosi2;

  spi_master #(.NBYTES(1), .CLKDIV(4)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .start(start), .din(din),
    .dout(dout), .busy(busy), .done(done), .select(select), .mclk(mclk), .mosi(mosi), .miso(miso)
  );
  spi_master #(.NBYTES(2), .CLKDIV(4)) dut2 (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .start(start2), .din(din2),
    .dout(dout2), .busy(busy2), .done(done2), .select(select2), .mclk(mclk2), .mosi(mosi2), .miso(miso2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic bit_of(input logic [7:0] v, input int n);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return n < 8 ? v[3'(n)] : 1'b0;
`else
    return n < 8 ? v[3'(7-n)] : 1'b0;
`endif
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] w, input logic b);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return {b, w[7:1]};
`else
    return {w[6:0], b};
`endif
  endfunction

  task automatic run1(input logic p, input logic h, input logic [7:0] d, input logic lb,
                      input logic [7:0] pat, input int inj_edge, input logic [7:0] d_inj);
    int bitn;
    logic pm, pmo, got_first, lead;
    cpol = p; cpha = h; din = d; loop = lb; bitn = 0;
    miso_s = bit_of(pat, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_mclk", mclk, p);
    chk("idle_select", select, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    r_cyc = 0; r_edges = 0; r_mosi_low = 0; r_wire = 0; r_first = 0; got_first = 0;
    pm = mclk; pmo = mosi;
    while (!done && r_cyc < 400) begin
      start = 1'b0;
      if (mclk !== pm) begin
        r_edges++;
        lead = (pm == p);
        if (lead ^ h) begin
          if (!got_first) begin r_first = pmo; got_first = 1; end
          r_wire = shift_in(r_wire, pmo);
        end
        if (lead) miso_s = ~bit_of(pat, bitn);
        else begin bitn++; miso_s = bit_of(pat, bitn); end
        if (r_edges == inj_edge) begin start = 1'b1; din = d_inj; end
      end
      if (select && !mosi) r_mosi_low = 1;
      pm = mclk; pmo = mosi;
      @(posedge clk);
      #1;
      r_cyc++;
    end
    start = 1'b0;
    r_busy_done = busy;
  endtask

  initial begin
    int n;
    logic seen_done;
    vt[0] = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'h00, 8'hA5};
    vt[1] = '{1'b0, 1'b1, 1'b1, 8'hA5, 8'h00, 8'hA5};
    vt[2] = '{1'b1, 1'b0, 1'b1, 8'hA5, 8'h00, 8'hA5};
    vt[3] = '{1'b1, 1'b1, 1'b1, 8'hA5, 8'h00, 8'hA5};
    vt[4] = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'h3C, 8'h3C};
    vt[5] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h3C, 8'h3C};
    vt[6] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 8'h01};
    vt[7] = '{1'b1, 1'b1, 1'b1, 8'h5A, 8'h00, 8'h5A};
    reset = 1'b1; cpol = 1'b0; cpha = 1'b0; start = 1'b0; din = 8'h00; loop = 1'b1; miso_s = 1'b0;
    start2 = 1'b0; din2 = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_select", select, 1'b0);
    chk("rst_mclk", mclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_dout2", dout2, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run1(vt[i].p, vt[i].h, vt[i].d, vt[i].lb, vt[i].pat, -1, 8'h00);
      chk($sformatf("v%0d_cycles", i), r_cyc, 73);
      chk($sformatf("v%0d_edges", i), r_edges, 16);
      chk($sformatf("v%0d_dout", i), dout, vt[i].exp);
      chk($sformatf("v%0d_wire", i), r_wire, vt[i].d);
      chk($sformatf("v%0d_first_bit", i), r_first, bit_of(vt[i].d, 0));
      chk($sformatf("v%0d_busy_on_done", i), r_busy_done, 1'b0);
      chk($sformatf("v%0d_select_end", i), select, 1'b0);
      chk($sformatf("v%0d_mclk_end", i), mclk, vt[i].p);
      if (!vt[i].lb) chk($sformatf("v%0d_mosi_low", i), r_mosi_low, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_width", i), done, 1'b0);
      chk($sformatf("v%0d_dout_hold", i), dout, vt[i].exp);
    end

    run1(1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, 5, 8'h3C);
    chk("inj_cycles", r_cyc, 73);
    chk("inj_dout", dout, 8'hA5);
    chk("inj_wire", r_wire, 8'hA5);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("start_on_done_ignored", busy, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_after_done_busy", busy, 1'b1);
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("after_done_frame_done", done, 1'b1);
    chk("after_done_frame_dout", dout, 8'h3C);

    cpol = 1'b1; cpha = 1'b0; din = 8'hC3; loop = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    begin
      logic pm;
      int ed;
      pm = mclk; ed = 0;
      while (ed < 7 && n < 400) begin
        @(posedge clk);
        #1;
        n++;
        if (mclk !== pm) ed++;
        pm = mclk;
      end
      chk("abort_reached_edge7", ed, 7);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_select", select, 1'b0);
    chk("abort_mclk", mclk, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_dout", dout, 8'h00);
    chk("abort_busy", busy, 1'b0);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", seen_done, 1'b0);
    chk("abort_dout_kept", dout, 8'h00);

    cpol = 1'b0; cpha = 1'b0; din2 = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("n2_cycles", n, 137);
    chk("n2_dout", dout2, 16'h1234);
    chk("n2_busy_on_done", busy2, 1'b0);
    chk("n2_select_end", select2, 1'b0);
    @(posedge clk);
    #1;
    chk("n2_done_width", done2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
